// File: rtl/uart_tx_stream.sv
// ============================================================================
// Module   : uart_tx_stream
// Brief    : Byte-stream 8N1 UART transmitter with a small input FIFO.
//            Bytes arrive over a valid/ready handshake, are queued, and are
//            sent LSB-first with one start and one stop bit. Consecutive
//            frames are emitted with no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_stream #(
  parameter int ClksPerBit = 104,
  parameter int DepthLog2  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int c_depth = 2 ** DepthLog2;
  localparam int c_ptr_w = DepthLog2 + 1;
  localparam int c_cnt_w = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(ClksPerBit - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and pointers (one extra wrap bit to tell full from empty)
  logic [7:0]         r_mem [c_depth];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic               r_ready;

  // Serializer state
  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_busy;

  // Combinational helpers
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_baud_wrap;
  logic [c_ptr_w-1:0] w_wr_ptr_nxt;
  logic [c_ptr_w-1:0] w_rd_ptr_nxt;
  logic               w_full_nxt;
  logic               w_empty_nxt;
  logic [7:0]         w_head;

  // Handshake, pop decision and next-pointer / flag computation
  always_comb begin
    w_empty      = (r_wr_ptr == r_rd_ptr);
    w_push       = valid_i && r_ready;
    w_baud_wrap  = (r_cnt == c_cnt_max);
    // Pop when idle, or at the very end of a stop bit so the next start
    // bit follows immediately.
    w_pop        = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_wrap));
    w_wr_ptr_nxt = r_wr_ptr + {{DepthLog2{1'b0}}, w_push};
    w_rd_ptr_nxt = r_rd_ptr + {{DepthLog2{1'b0}}, w_pop};
    w_full_nxt   = (w_wr_ptr_nxt[DepthLog2] != w_rd_ptr_nxt[DepthLog2]) &&
                   (w_wr_ptr_nxt[DepthLog2-1:0] == w_rd_ptr_nxt[DepthLog2-1:0]);
    w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    w_head       = r_mem[r_rd_ptr[DepthLog2-1:0]];
  end

  // FIFO pointers plus registered ready, which reflects "not full" after each edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_ready  <= !w_full_nxt;
    end
  end

  // FIFO storage write on an accepted handshake
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DepthLog2-1:0]] <= data_i;
    end
  end

  // Frame sequencer: drives tx, busy, baud counter and shift register from flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_cnt     <= '0;
          r_bit_idx <= 3'd0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            // A byte pushed this edge makes the block busy straight away
            r_busy <= !w_empty_nxt;
          end
        end

        S_START: begin
          r_busy <= 1'b1;
          if (w_baud_wrap) begin
            r_cnt   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end

        S_DATA: begin
          r_busy <= 1'b1;
          if (w_baud_wrap) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end

        S_STOP: begin
          if (w_baud_wrap) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= S_START;
              r_tx    <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
              r_busy  <= !w_empty_nxt;
            end
          end else begin
            r_cnt  <= r_cnt + c_cnt_w'(1);
            r_busy <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign tx_o    = r_tx;
  assign busy_o  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
// ============================================================================
// Module   : tb_uart_tx_stream
// Brief    : Self-checking bench for uart_tx_stream. Bytes accepted on the
//            handshake are queued as expectations; the serial line is
//            recorded every cycle and decoded by a sampling UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_stream;

  localparam int C  = 4;
  localparam int DL = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit         line_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  int         dec_pos_q[$];
  int         frame_err;
  int         last_acc;

  uart_tx_stream #(
    .ClksPerBit(C),
    .DepthLog2 (DL)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // cycle counter, advanced on every rising edge
  always @(posedge clk_i) cyc <= cyc + 1;

  // record the serial line once per cycle, away from the active edge
  always @(negedge clk_i) if (!rst_i) line_q.push_back(tx_o);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ideal 8N1 waveform, one sample per clock, first sample in bit 0
  function automatic logic [63:0] frame_wave(input logic [7:0] b);
    logic [9:0]  bits;
    logic [63:0] w;
    bits = {1'b1, b, 1'b0};
    w = '0;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < C; j++)
        w[k*C + j] = bits[k];
    return w;
  endfunction

  // UART receiver model: find a falling line, sample each bit mid-period
  task automatic decode_line();
    int i;
    logic [7:0] b;
    dec_q.delete();
    dec_pos_q.delete();
    frame_err = 0;
    i = 0;
    while (i < line_q.size()) begin
      if (line_q[i] == 1'b0) begin
        if (i + 10*C > line_q.size()) begin
          frame_err++;
          break;
        end
        if (line_q[i + C/2] != 1'b0) frame_err++;
        for (int k = 0; k < 8; k++) b[k] = line_q[i + C*(k+1) + C/2];
        if (line_q[i + 9*C + C/2] != 1'b1) frame_err++;
        dec_q.push_back(b);
        dec_pos_q.push_back(i);
        i += 10*C;
      end else begin
        i++;
      end
    end
  endtask

  // Offer one byte after an optional random gap; returns after the transfer edge
  task automatic push_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int guard;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      data_i  = 8'($urandom);
    end
    @(negedge clk_i);
    valid_i = 1'b1;
    data_i  = b;
    guard   = 0;
    while (!ready_o && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 2000) begin
      check("push_timeout", 64'(guard), 64'd0);
    end else begin
      @(posedge clk_i);
      #1;
      exp_q.push_back(b);
      last_acc = cyc;
    end
  endtask

  // Wait for the transmitter to go quiet, then decode and compare everything
  task automatic drain(input string tag);
    int g;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    g = 0;
    while (busy_o && g < 5000) begin
      @(negedge clk_i);
      g++;
    end
    check({tag, "_busy_timeout"}, 64'(g < 5000), 64'd1);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    decode_line();
    check({tag, "_nframes"}, 64'(dec_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < dec_q.size() && k < exp_q.size(); k++)
      check({tag, "_byte"}, 64'(dec_q[k]), 64'(exp_q[k]));
    check({tag, "_framing"}, 64'(frame_err), 64'd0);
    line_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int base;
    int t[6];
    int bad;
    logic [63:0] wave;

    // ---------------- reset and release ----------------
    #3 rst_i = 1'b1;
    #1;
    check("rst_tx", 64'(tx_o), 64'd1);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rel_ready_before_edge", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    check("rel_ready_after_edge", 64'(ready_o), 64'd1);
    check("rel_tx", 64'(tx_o), 64'd1);

    // ---------------- single byte 0x55 with exact timing ----------------
    @(negedge clk_i);
    valid_i = 1'b1;
    data_i  = 8'h55;
    @(posedge clk_i);
    #1;
    base = line_q.size();
    exp_q.push_back(8'h55);
    @(negedge clk_i);
    valid_i = 1'b0;
    data_i  = 8'h00;
    check("single_tx_after_accept", 64'(tx_o), 64'd1);
    check("single_busy_after_accept", 64'(busy_o), 64'd1);
    repeat (40) @(negedge clk_i);
    check("single_busy_in_stop", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    check("single_busy_cleared", 64'(busy_o), 64'd0);
    check("single_tx_idle", 64'(tx_o), 64'd1);
    @(posedge clk_i);
    #1;
    wave = '0;
    for (int k = 0; k < 10*C; k++) wave[k] = line_q[base + 1 + k];
    check("single_wave", wave, frame_wave(8'h55));
    drain("single");

    // ---------------- data extremes back-to-back ----------------
    push_byte(8'h00, 0);
    push_byte(8'hFF, 0);
    push_byte(8'hE7, 0);
    drain("extremes");
    if (dec_pos_q.size() == 3) begin
      check("extremes_gap01", 64'(dec_pos_q[1] - dec_pos_q[0]), 64'(10*C));
      check("extremes_gap12", 64'(dec_pos_q[2] - dec_pos_q[1]), 64'(10*C));
    end else begin
      check("extremes_positions", 64'(dec_pos_q.size()), 64'd3);
    end

    // ---------------- FIFO fill ----------------
    for (int k = 0; k < 5; k++) begin
      push_byte(8'(k + 1), 0);
      t[k] = last_acc;
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    check("fill_ready_low_when_full", 64'(ready_o), 64'd0);
    for (int k = 1; k < 5; k++)
      check("fill_accept_cycle", 64'(t[k] - t[0]), 64'(k));
    push_byte(8'h06, 0);
    t[5] = last_acc;
    check("fill_sixth_after_pop", 64'(t[5] - t[0]), 64'(10*C + 2));
    @(negedge clk_i);
    valid_i = 1'b0;
    check("fill_ready_low_again", 64'(ready_o), 64'd0);
    drain("fill");

    // ---------------- valid gating ----------------
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      data_i  = (k % 2 == 0) ? 8'hAA : 8'h00;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    check("gating_line_quiet", 64'(bad), 64'd0);
    drain("gating");

    // ---------------- reset mid-frame ----------------
    push_byte(8'h3C, 0);
    push_byte(8'h11, 0);
    push_byte(8'h22, 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("midrst_tx_in_data", 64'(tx_o), 64'd0);
    check("midrst_ready_before", 64'(ready_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_tx_async", 64'(tx_o), 64'd1);
    check("midrst_ready_async", 64'(ready_o), 64'd0);
    check("midrst_busy_async", 64'(busy_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    line_q.delete();
    exp_q.delete();
    @(negedge clk_i);
    check("midrst_ready_after_release", 64'(ready_o), 64'd1);
    repeat (60) @(negedge clk_i);
    check("midrst_no_busy", 64'(busy_o), 64'd0);
    drain("midrst_residual");
    push_byte(8'h81, 0);
    drain("midrst_new");

    // ---------------- randomized streams ----------------
    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(6, 14));
      for (int k = 0; k < n; k++)
        push_byte(8'($urandom), (r == 0) ? 0 : 3 + r * 20);
      drain("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_stream.md
# uart_tx_stream

Byte-stream UART transmitter that sits at the output end of the ALU path. It accepts result bytes from the ALU over a valid/ready handshake and buffers them in a small FIFO. It serializes each byte as an 8N1 frame (1 start, 8 data LSB-first, 1 stop, no parity) on the board TX pin, so the ALU never stalls on serial line rate until the FIFO fills.

## Interface
- ClksPerBit, default 104: clock cycles per serial bit (12 MHz / 115200 baud); legal range ≥ 2.
- DepthLog2, default 2: FIFO depth is 2**DepthLog2 entries (default 4); legal range ≥ 1.
- clk_i  input  1  single system clock; all logic on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_i  input  8  byte to transmit; sampled when valid_i && ready_o at a rising edge.
- valid_i  input  1  upstream byte valid.
- ready_o  output  1  FIFO can accept a byte this cycle.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  a frame is in progress or the FIFO is non-empty.

## Operation
- Handshake: a byte is transferred on every rising edge where valid_i && ready_o. With valid_i high, upstream holds data_i stable until the transfer. valid_i low means no push, whatever data_i is.
- ready_o is registered and equals "FIFO not full" after the edge.
- A pop in the same edge frees space, and ready_o rises after that edge.
- FIFO: circular buffer with pointers of DepthLog2+1 bits. Pointers wrap modulo 2**(DepthLog2+1). Full and empty are derived from the MSB and the low bits of the pointers. Order is strictly FIFO.
- A simultaneous push and pop in one edge is legal at any non-full occupancy and leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and bit index, and go to START.
  - START: tx_o=0 for ClksPerBit cycles, then go to DATA.
  - DATA: tx_o = shift[0] for ClksPerBit cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - STOP: tx_o=1 for ClksPerBit cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter counts 0..ClksPerBit-1 and wraps; bit advance occurs on the wrap. Counter width is $clog2(ClksPerBit).
- tx_o is driven from a flop, with no combinational path from inputs.
- busy_o = (state != IDLE) || FIFO non-empty, registered.

## Timing
- Reset values, applied asynchronously while rst_i=1:
  - tx_o=1, ready_o=0, busy_o=0.
  - state=IDLE, FIFO empty, counters 0.
- ready_o rises at the first rising edge after rst_i deasserts.
- Latency for an empty FIFO in IDLE:
  - Byte accepted at edge N → FIFO count 1 after N.
  - Pop at edge N+1 → tx_o=0 from edge N+1.
  - Start bit spans edges N+1..N+1+ClksPerBit.
- Frame length is exactly 10*ClksPerBit cycles. Back-to-back frames have zero idle cycles between a stop bit and the next start bit.
- Throughput: one byte per 10*ClksPerBit cycles.
  - With continuous valid_i, the FIFO absorbs 2**DepthLog2 bytes; the in-flight byte has already been popped and does not count.
  - After that, ready_o toggles high for one cycle per completed pop.
- Full boundary: with the FIFO full, ready_o=0 and data_i is ignored even when valid_i=1.
- Reset mid-frame: tx_o returns to 1 immediately (async), the partial frame is aborted, and FIFO contents are discarded. After release, behaviour is identical to power-up.

## Test plan
- Single byte, ClksPerBit=4: send 0x55.
  - tx_o low 4 cycles starting the edge after the pop.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each.
  - Then high 4 cycles; busy_o clears after the stop bit.
  - The bench's UART model decodes 0x55.
- Data extremes: send 0x00, 0xFF, 0xE7 back-to-back.
  - Bench decodes 0x00, 0xFF, 0xE7 in order.
  - tx_o has no idle gap between frames (total 30*ClksPerBit cycles from first start bit).
- FIFO fill, DepthLog2=2: hold valid_i with bytes 0x01..0x06.
  - 0x01 is popped to the shifter; 0x02..0x05 fill the FIFO; ready_o drops.
  - 0x06 is accepted only after 0x02 is popped.
  - All six decode in order.
- Valid gating: pulse data_i=0xAA with valid_i=0 for 20 cycles → tx_o stays 1, busy_o stays 0, no frame.
- Reset mid-frame: assert rst_i during the data bits of 0x3C with 2 bytes queued.
  - tx_o goes 1 immediately; ready_o and busy_o go 0.
  - After release, no residual frame appears; a new 0x81 decodes correctly.
- Reset release: ready_o=0 while rst_i=1 and goes 1 one edge after release; tx_o is 1 throughout.
